// File: rtl/pll_lock_sequencer_if.sv
// Handshake bundle between the PLL lock sequencer and its PLL / system-reset environment.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface pll_lock_sequencer_if;
  logic       locked_in;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout_err;
  logic [7:0] relock_count;

  modport master (
    output locked_in, force_relock,
    input  pll_rst, sys_rst, ready, timeout_err, relock_count
  );

  modport slave (
    input  locked_in, force_relock,
    output pll_rst, sys_rst, ready, timeout_err, relock_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Board PLL reset/lock sequencer: pulses the PLL reset, qualifies a stable lock, then
// releases the system reset; restarts on lock loss, lock timeout or a software request.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int DROP_FILTER  = 4,
  parameter int CNT_W        = 16
) (
  input logic                 refclk,
  input logic                 rst,
  pll_lock_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DROP_LAST    = CNT_W'(DROP_FILTER - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic             relock_inc;
  logic             timeout_hit;

  // locked_in is asynchronous to refclk; only the second stage is ever used.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], bus.locked_in};
  end

  assign locked_s = sync_q[1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    relock_inc  = 1'b0;
    timeout_hit = 1'b0;
    if (bus.force_relock && state != ST_ASSERT) begin
      state_next = ST_ASSERT;
      cnt_next   = '0;
      relock_inc = 1'b1;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == RST_LAST) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_next = ST_STABLE;
            cnt_next   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state_next  = ST_ASSERT;
            cnt_next    = '0;
            timeout_hit = 1'b1;
            relock_inc  = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          // cnt tracks consecutive unlocked samples; short glitches never reach DROP_LAST.
          if (locked_s) begin
            cnt_next = '0;
          end else if (cnt == DROP_LAST) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
            relock_inc = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state            <= ST_ASSERT;
      cnt              <= '0;
      bus.pll_rst      <= 1'b1;
      bus.sys_rst      <= 1'b1;
      bus.ready        <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.relock_count <= '0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      bus.pll_rst     <= (state_next == ST_ASSERT);
      bus.sys_rst     <= (state_next != ST_RUN);
      bus.ready       <= (state_next == ST_RUN);
      bus.timeout_err <= bus.timeout_err | timeout_hit;
      if (relock_inc && bus.relock_count != 8'hFF)
        bus.relock_count <= bus.relock_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_STABLE=8,
// LOCK_TIMEOUT=100, DROP_FILTER=3; inputs change and outputs are sampled 1 time unit after posedge.
module tb_pll_lock_sequencer;

  logic refclk;
  logic rst;
  int   vectors;
  int   miscompares;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES  (4),
    .LOCK_STABLE (8),
    .LOCK_TIMEOUT(100),
    .DROP_FILTER (3),
    .CNT_W       (16)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Call at the first sample where pll_rst is high; returns the number of high samples.
  task automatic pulse_len(output int n);
    n = 0;
    while (bus.pll_rst === 1'b1 && n < 50) begin
      n++;
      step();
    end
  endtask

  // PLL model: lock appears 20 cycles after pll_rst falls; returns cycles until sys_rst falls.
  task automatic lock_to_run(output int n);
    repeat (20) step();
    bus.locked_in = 1'b1;
    n = 0;
    while (bus.sys_rst === 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic apply_reset();
    rst              = 1'b1;
    bus.locked_in    = 1'b0;
    bus.force_relock = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic go_run();
    int n;
    apply_reset();
    pulse_len(n);
    lock_to_run(n);
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.locked_in    = 1'b0;
    bus.force_relock = 1'b0;
    repeat (3) step();
    vectors++;
    if (bus.pll_rst !== 1'b1) begin
      miscompares++; $display("FAIL reset_pll_rst: got %b want 1", bus.pll_rst);
    end
    vectors++;
    if (bus.sys_rst !== 1'b1 || bus.ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_sys: sys_rst=%b ready=%b want 1/0", bus.sys_rst, bus.ready);
    end
    vectors++;
    if (bus.timeout_err !== 1'b0 || bus.relock_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_status: timeout_err=%b relock_count=%0d want 0/0",
                              bus.timeout_err, bus.relock_count);
    end
  endtask

  task automatic test_bringup();
    int n;
    apply_reset();
    pulse_len(n);
    vectors++;
    if (n != 4) begin
      miscompares++; $display("FAIL bringup_pll_pulse: got %0d cycles want 4", n);
    end
    lock_to_run(n);
    // 2 synchronizer cycles + 1 WAIT_LOCK decision + 8 STABLE cycles
    vectors++;
    if (n != 11) begin
      miscompares++; $display("FAIL bringup_release: got %0d cycles want 11", n);
    end
    vectors++;
    if (bus.ready !== 1'b1 || bus.pll_rst !== 1'b0) begin
      miscompares++; $display("FAIL bringup_ready: ready=%b pll_rst=%b want 1/0", bus.ready, bus.pll_rst);
    end
    vectors++;
    if (bus.relock_count !== 8'd0 || bus.timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL bringup_status: relock_count=%0d timeout_err=%b want 0/0",
                              bus.relock_count, bus.timeout_err);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    pulse_len(n);
    vectors++;
    if (bus.timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout_err_early: got %b want 0", bus.timeout_err);
    end
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (bus.pll_rst === 1'b0 && n < 300) begin
        step();
        n++;
      end
      vectors++;
      if (n != 100) begin
        miscompares++; $display("FAIL timeout_wait_%0d: got %0d cycles want 100", k, n);
      end
      vectors++;
      if (bus.timeout_err !== 1'b1 || bus.relock_count !== 8'(k)) begin
        miscompares++; $display("FAIL timeout_status_%0d: timeout_err=%b relock_count=%0d want 1/%0d",
                                k, bus.timeout_err, bus.relock_count, k);
      end
      pulse_len(n);
      vectors++;
      if (n != 4) begin
        miscompares++; $display("FAIL timeout_pulse_%0d: got %0d cycles want 4", k, n);
      end
    end
  endtask

  task automatic test_glitch();
    int n;
    int bad;
    go_run();
    bus.locked_in = 1'b0;
    step();
    step();
    bus.locked_in = 1'b1;
    bad = 0;
    repeat (10) begin
      step();
      if (bus.ready !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL glitch2_ready: ready low for %0d samples want 0", bad);
    end
    vectors++;
    if (bus.relock_count !== 8'd0) begin
      miscompares++; $display("FAIL glitch2_count: got %0d want 0", bus.relock_count);
    end
    bus.locked_in = 1'b0;
    n = 0;
    while (bus.pll_rst === 1'b0 && n < 50) begin
      step();
      n++;
    end
    // 2 synchronizer cycles + 3 filtered low samples
    vectors++;
    if (n != 5) begin
      miscompares++; $display("FAIL drop_latency: got %0d cycles want 5", n);
    end
    vectors++;
    if (bus.sys_rst !== 1'b1 || bus.ready !== 1'b0 || bus.relock_count !== 8'd1) begin
      miscompares++; $display("FAIL drop_state: sys_rst=%b ready=%b relock_count=%0d want 1/0/1",
                              bus.sys_rst, bus.ready, bus.relock_count);
    end
    pulse_len(n);
    vectors++;
    if (n != 4) begin
      miscompares++; $display("FAIL drop_pulse: got %0d cycles want 4", n);
    end
    lock_to_run(n);
    vectors++;
    if (n != 11 || bus.ready !== 1'b1 || bus.relock_count !== 8'd1) begin
      miscompares++; $display("FAIL drop_recover: cycles=%0d ready=%b relock_count=%0d want 11/1/1",
                              n, bus.ready, bus.relock_count);
    end
  endtask

  task automatic test_unstable();
    int n;
    int early;
    apply_reset();
    pulse_len(n);
    repeat (20) step();
    bus.locked_in = 1'b1;
    repeat (5) step();
    bus.locked_in = 1'b0;
    early = 0;
    repeat (15) begin
      step();
      if (bus.sys_rst !== 1'b1 || bus.pll_rst !== 1'b0) early++;
    end
    vectors++;
    if (early != 0) begin
      miscompares++; $display("FAIL unstable_hold: %0d bad samples want 0", early);
    end
    lock_to_run(n);
    vectors++;
    if (n != 11) begin
      miscompares++; $display("FAIL unstable_release: got %0d cycles want 11", n);
    end
    vectors++;
    if (bus.ready !== 1'b1 || bus.relock_count !== 8'd0) begin
      miscompares++; $display("FAIL unstable_status: ready=%b relock_count=%0d want 1/0",
                              bus.ready, bus.relock_count);
    end
  endtask

  task automatic test_force();
    int n;
    go_run();
    bus.force_relock = 1'b1;
    bus.locked_in    = 1'b0;
    step();
    bus.force_relock = 1'b0;
    vectors++;
    if (bus.pll_rst !== 1'b1 || bus.sys_rst !== 1'b1 || bus.ready !== 1'b0) begin
      miscompares++; $display("FAIL force_outputs: pll_rst=%b sys_rst=%b ready=%b want 1/1/0",
                              bus.pll_rst, bus.sys_rst, bus.ready);
    end
    vectors++;
    if (bus.relock_count !== 8'd1) begin
      miscompares++; $display("FAIL force_count: got %0d want 1", bus.relock_count);
    end
    // A second request lands in the second ASSERT cycle and must be ignored.
    n = 0;
    while (bus.pll_rst === 1'b1 && n < 50) begin
      bus.force_relock = (n == 1);
      n++;
      step();
    end
    bus.force_relock = 1'b0;
    vectors++;
    if (n != 4) begin
      miscompares++; $display("FAIL force_in_assert_pulse: got %0d cycles want 4", n);
    end
    vectors++;
    if (bus.relock_count !== 8'd1) begin
      miscompares++; $display("FAIL force_in_assert_count: got %0d want 1", bus.relock_count);
    end
  endtask

  task automatic test_saturation_and_reset();
    int n;
    apply_reset();
    pulse_len(n);
    n = 0;
    while (bus.pll_rst === 1'b0 && n < 300) begin
      step();
      n++;
    end
    pulse_len(n);
    for (int i = 2; i <= 260; i++) begin
      bus.force_relock = 1'b1;
      step();
      bus.force_relock = 1'b0;
      pulse_len(n);
      if (i == 254 || i == 255 || i == 260) begin
        vectors++;
        if (bus.relock_count !== 8'((i > 255) ? 255 : i)) begin
          miscompares++; $display("FAIL saturate_%0d: got %0d want %0d",
                                  i, bus.relock_count, (i > 255) ? 255 : i);
        end
      end
    end
    bus.locked_in = 1'b1;
    repeat (6) step();
    vectors++;
    if (bus.sys_rst !== 1'b1 || bus.pll_rst !== 1'b0 || bus.timeout_err !== 1'b1) begin
      miscompares++; $display("FAIL pre_rst_stable: sys_rst=%b pll_rst=%b timeout_err=%b want 1/0/1",
                              bus.sys_rst, bus.pll_rst, bus.timeout_err);
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (bus.pll_rst !== 1'b1 || bus.sys_rst !== 1'b1 || bus.ready !== 1'b0) begin
      miscompares++; $display("FAIL async_rst_outputs: pll_rst=%b sys_rst=%b ready=%b want 1/1/0",
                              bus.pll_rst, bus.sys_rst, bus.ready);
    end
    vectors++;
    if (bus.relock_count !== 8'd0 || bus.timeout_err !== 1'b0) begin
      miscompares++; $display("FAIL async_rst_status: relock_count=%0d timeout_err=%b want 0/0",
                              bus.relock_count, bus.timeout_err);
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    bus.locked_in    = 1'b0;
    bus.force_relock = 1'b0;
    test_reset();
    test_bringup();
    test_timeout();
    test_glitch();
    test_unstable();
    test_force();
    test_saturation_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
